// File: rtl/ifft4_stream.sv
// ifft4_stream: streaming 4-point inverse FFT, two registered radix-2 stages with 1/2 scaling each
module ifft4_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o
);
  localparam int HALF = WIDTH / 2;
  typedef enum logic [1:0] {COLLECT, STAGE1, STAGE2, EMIT} state_t;
  state_t           state_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] p0_q, p1_q, q0_q, q1_q;
  // one extra bit of headroom, then floor-halve by dropping the LSB
  function automatic logic [HALF-1:0] hs(input logic [HALF-1:0] a, input logic [HALF-1:0] b, input logic sub);
    logic [HALF:0] s;
    s = sub ? {a[HALF-1], a} - {b[HALF-1], b} : {a[HALF-1], a} + {b[HALF-1], b};
    return s[HALF:1];
  endfunction
  function automatic logic [WIDTH-1:0] cs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    return {hs(a[WIDTH-1:HALF], b[WIDTH-1:HALF], sub), hs(a[HALF-1:0], b[HALF-1:0], sub)};
  endfunction
  assign in_ready_o  = state_q == COLLECT;
  assign out_valid_o = state_q == EMIT;
  assign out_data_o  = out_valid_o ? buf_q[idx_q] : '0;
  assign out_last_o  = out_valid_o && idx_q == 2'd3;
  // frame FSM: collect, butterfly stage 1, butterfly stage 2 (results overwrite the input buffer), emit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        COLLECT: if (in_valid_i) begin
          buf_q[idx_q] <= in_data_i;
          idx_q        <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= STAGE1;
        end
        STAGE1: begin
          p0_q    <= cs(buf_q[0], buf_q[2], 1'b0);
          p1_q    <= cs(buf_q[0], buf_q[2], 1'b1);
          q0_q    <= cs(buf_q[1], buf_q[3], 1'b0);
          q1_q    <= cs(buf_q[1], buf_q[3], 1'b1);
          state_q <= STAGE2;
        end
        STAGE2: begin
          buf_q[0] <= cs(p0_q, q0_q, 1'b0);
          buf_q[2] <= cs(p0_q, q0_q, 1'b1);
          buf_q[1] <= {hs(p1_q[WIDTH-1:HALF], q1_q[HALF-1:0], 1'b1), hs(p1_q[HALF-1:0], q1_q[WIDTH-1:HALF], 1'b0)};
          buf_q[3] <= {hs(p1_q[WIDTH-1:HALF], q1_q[HALF-1:0], 1'b0), hs(p1_q[HALF-1:0], q1_q[WIDTH-1:HALF], 1'b1)};
          state_q  <= EMIT;
        end
        EMIT: if (out_ready_i) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft4_stream.sv
// tb_ifft4_stream: directed-vector bench for ifft4_stream
module tb_ifft4_stream;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data, out_data;
  int          n_cmp = 0, n_bad = 0, cyc = 0, t_a, t_b;
  logic [127:0] one_all, bin1;

  ifft4_stream #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] c(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [127:0] f4(input logic [31:0] a, b, d, e);
    return {e, d, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge following the X3 handshake
  task automatic send(input logic [127:0] x, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = x[32*k +: 32];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic recv(input logic [127:0] e, input bit stall, input bit junk, input int lat);
    int cnt = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = c(1000, -1000);
    end
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("out_valid_rise", {63'd0, out_valid}, 64'd1);
    if (lat >= 0) chk("latency", 64'(cnt), 64'(lat));
    if (!out_valid) return;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("x%0d", n), {32'd0, out_data}, {32'd0, e[32*n +: 32]});
      chk($sformatf("last%0d", n), {63'd0, out_last}, {63'd0, n == 3});
      if (junk) chk("in_ready_emit", {63'd0, in_ready}, 64'd0);
      if (stall && n == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("hold_valid", {63'd0, out_valid}, 64'd1);
          chk("hold_x1", {32'd0, out_data}, {32'd0, e[63:32]});
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("in_ready_after", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    one_all  = f4(c(1, 0), c(1, 0), c(1, 0), c(1, 0));
    bin1     = f4(c(1, 0), c(0, 1), c(-1, 0), c(0, -1));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // impulse with latency check
    send(f4(c(4, 0), 0, 0, 0), 1'b0);
    recv(one_all, 1'b0, 1'b0, 2);
    // single bin: +j twiddle
    send(f4(0, c(4, 0), 0, 0), 1'b0);
    recv(bin1, 1'b0, 1'b0, 2);
    // floor rounding and extremes
    send(f4(c(-1, 0), 0, 0, 0), 1'b0);
    recv(f4(c(-1, 0), c(-1, 0), c(-1, 0), c(-1, 0)), 1'b0, 1'b0, -1);
    send(f4(c(32767, 0), c(32767, 0), c(32767, 0), c(32767, 0)), 1'b0);
    recv(f4(c(32767, 0), 0, 0, 0), 1'b0, 1'b0, -1);
    send(f4(c(-32768, -32768), c(-32768, -32768), c(-32768, -32768), c(-32768, -32768)), 1'b0);
    recv(f4(c(-32768, -32768), 0, 0, 0), 1'b0, 1'b0, -1);
    // input gaps, output stall on x1, input offered during EMIT
    send(f4(0, c(4, 0), 0, 0), 1'b1);
    recv(bin1, 1'b1, 1'b1, -1);
    send(f4(c(4, 0), 0, 0, 0), 1'b0);
    recv(one_all, 1'b0, 1'b0, -1);
    // reset after two inputs
    in_valid = 1'b1;
    in_data  = c(100, 0);
    @(negedge clk);
    in_data  = c(200, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstc_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rstc_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstc_out_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(f4(c(4, 0), 0, 0, 0), 1'b0);
    recv(one_all, 1'b0, 1'b0, 2);
    // reset mid-EMIT
    send(f4(0, c(4, 0), 0, 0), 1'b0);
    repeat (2) @(negedge clk);
    chk("emit_x0", {32'd0, out_data}, {32'd0, c(1, 0)});
    @(negedge clk);
    chk("emit_x1", {32'd0, out_data}, {32'd0, c(0, 1)});
    #2 rst_n = 1'b0;
    #1;
    chk("rste_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rste_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rste_out_data", {32'd0, out_data}, 64'd0);
    chk("rste_out_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(f4(c(4, 0), 0, 0, 0), 1'b0);
    recv(one_all, 1'b0, 1'b0, 2);
    // back-to-back frames: 10-cycle period
    t_a = cyc;
    send(f4(c(4, 0), 0, 0, 0), 1'b0);
    recv(one_all, 1'b0, 1'b0, 2);
    t_b = cyc;
    send(f4(0, c(4, 0), 0, 0), 1'b0);
    recv(bin1, 1'b0, 1'b0, 2);
    chk("frame_period", 64'(t_b - t_a), 64'd10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifft4_stream.md
# ifft4_stream

Streaming 4-point inverse FFT engine for the 4-point FFT datapath. It accepts one frame of four packed complex frequency-domain samples X[0..3] over a valid/ready input, then computes x[n] = (1/4)·Σ X[k]·e^{+j2πkn/4} in two registered radix-2 stages. It returns x[0..3] in natural order over a valid/ready output. It is the return path for data produced by the forward FFT, so a forward-then-inverse round trip reconstructs the time samples.

## Interface
- WIDTH, 32, packed complex sample width; real part in [WIDTH-1:HALF], imaginary part in [HALF-1:0], each signed two's complement.
- HALF, WIDTH/2, component width (derived, not overridable).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a valid X[k].
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  packed {re, im} of X[k], supplied in order k = 0, 1, 2, 3.
- out_valid  output  1  out_data holds a valid x[n].
- out_ready  input  1  downstream accepts a sample this cycle.
- out_data  output  WIDTH  packed {re, im} of x[n], supplied in order n = 0, 1, 2, 3.
- out_last  output  1  high with out_valid when n = 3.

## Operation
- FSM states: COLLECT, STAGE1, STAGE2, EMIT.
- **COLLECT**
  - in_ready = 1.
  - Each handshake (in_valid & in_ready) stores in_data into buffer slot idx, then increments the 2-bit idx.
  - The handshake at idx = 3 moves to STAGE1 and sets idx = 0.
- **STAGE1** (one cycle, computes into stage registers)
  - P0 = (X0 + X2) >>> 1
  - P1 = (X0 − X2) >>> 1
  - Q0 = (X1 + X3) >>> 1
  - Q1 = (X1 − X3) >>> 1
  - Then go to STAGE2.
- **STAGE2** (one cycle)
  - x0 = (P0 + Q0) >>> 1
  - x2 = (P0 − Q0) >>> 1
  - x1 = (P1r − Q1i, P1i + Q1r) >>> 1
  - x3 = (P1r + Q1i, P1i − Q1r) >>> 1
  - Then go to EMIT.
- **EMIT**
  - out_valid = 1, out_data = x[idx], out_last = (idx == 3).
  - Each handshake (out_valid & out_ready) increments idx.
  - The handshake at idx = 3 returns to COLLECT with idx = 0.
- **Arithmetic**
  - Per component: sign-extend both operands to HALF+1 bits, add or subtract, arithmetic shift right 1 (floor), keep the low HALF bits. The result always fits, so overflow is impossible.
  - Twiddles (1, +j) are applied exactly as swap and negate. There are no multipliers and no Q15 approximation.
  - Total scaling is 1/4 with floor rounding per stage.
- **Flow control**
  - No frame overlap: in_ready = 0 in STAGE1, STAGE2 and EMIT.
  - Input is ignored in those states even if in_valid = 1.
- **Reset** (asynchronous, any state, including mid-COLLECT or mid-EMIT)
  - state = COLLECT, idx = 0.
  - out_valid = 0, out_last = 0, out_data = 0.
  - All buffers and stage registers = 0.
  - A partial frame is discarded. in_ready = 1 while rst_n is low and after release.

## Timing
- in_ready is combinational from state only.
- out_valid, out_data and out_last are driven from registered state, idx and buffer. There is no combinational path from in_* or out_ready to any output.
- Let E0 be the edge accepting X3:
  - STAGE1 during cycle E0..E1.
  - STAGE2 during E1..E2.
  - out_valid first high after E2, so latency is 2 cycles from the last input handshake.
- With out_ready held at 1, x0..x3 appear on 4 consecutive cycles. in_ready rises the cycle after the x3 handshake edge.
- Minimum frame period is 4 (in) + 2 + 4 (out) = 10 cycles.
- out_ready = 0 holds out_data, out_last and idx stable with out_valid = 1 for any number of cycles.
- in_valid gaps in COLLECT stall collection; idx holds.

## Test plan
- Impulse: X = [4+0j, 0, 0, 0] -> x = [1+0j, 1+0j, 1+0j, 1+0j], out_last only on the 4th; out_valid rises 2 cycles after the X3 handshake.
- Single bin: X = [0, 4+0j, 0, 0] -> x = [1+0j, 0+1j, −1+0j, 0−1j]; confirms the +j twiddle sign (inverse direction).
- Floor rounding / extremes:
  - X = [−1+0j, 0, 0, 0] -> all x = −1+0j.
  - X = [32767+0j ×4] -> x = [32767+0j, 0, 0, 0].
  - X = [−32768−32768j ×4] -> x0 = −32768−32768j, others 0.
- Backpressure and gaps:
  - in_valid toggling 1,0,1,0… during COLLECT -> same results as contiguous input.
  - out_ready low for 3 cycles while x1 is presented -> x1 is held stable, no sample is lost or duplicated.
  - in_valid = 1 during EMIT -> in_ready = 0 and no sample is captured.
- Reset mid-operation:
  - Assert rst_n = 0 after 2 inputs -> outputs are 0 immediately (asynchronous) and in_ready = 1.
  - A following full frame [4, 0, 0, 0] -> all 1+0j.
  - Repeat with reset asserted mid-EMIT.
- Back-to-back frames with out_ready = 1: impulse frame followed by single-bin frame -> 10-cycle period, both correct.
